serial_pair_adder_ctrl: RTL and testbench
=========================================

// Module: serial_pair_adder_ctrl
// PURPOSE
//   Sequences a 2-bit adder slice (2-bit + 2-bit + carry-in) to add two WIDTH-bit operands,
//   two bits per clock, least-significant pair first, holding the carry in a register.
//   Operands are latched on a start handshake. The WIDTH+1-bit result is presented with a
//   one-cycle done pulse. On Nexys4 DDR, sits between switch/button inputs and LED outputs.
// PARAMETERS
//   WIDTH   8   operand width in bits; must be even and >= 2 (NSLICE = WIDTH/2 slice steps)
// PORTS
//   clk     in   1          system clock, rising-edge active
//   rst     in   1          asynchronous, active-high reset
//   start   in   1          request; sampled on a rising edge only while busy==0
//   cin     in   1          carry-in to the least-significant slice, latched with start
//   a       in   WIDTH      operand A, latched on accepted start
//   b       in   WIDTH      operand B, latched on accepted start
//   busy    out  1          high while an addition is in progress
//   done    out  1          one-cycle pulse: sum is valid and newly updated
//   sum     out  WIDTH+1    result {carry_out, sum_bits}; held until next completion
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0.
//     Clears carry reg, slice counter and shift regs. Takes effect immediately, mid-operation too.
//     The in-flight addition is discarded and no done pulse is produced.
//   States: IDLE, RUN.
//   IDLE: on a rising edge with start=1:
//     - latch a, b into shift regs; carry reg <= cin; cnt <= 0
//     - go to RUN; busy=1 from that edge
//     - start=0 keeps IDLE
//   RUN, each rising edge (slice step k = cnt):
//     - {c, s[1:0]} = a_sh[1:0] + b_sh[1:0] + carry (3-bit, no truncation)
//     - s shifts into the result shift reg from the MSB end; carry <= c
//     - a_sh, b_sh shift right by 2; cnt <= cnt+1
//   At the edge performing step NSLICE-1:
//     - sum <= {c, result bits}; done <= 1; busy <= 0; state -> IDLE
//   Latency: start accepted at edge E0; sum valid and done=1 after edge E0+NSLICE;
//     busy high for exactly NSLICE cycles.
//   done: registered; high exactly one cycle; cleared on the next edge unless another completion occurs.
//   start while busy=1: ignored (not queued); operand pins may change freely during RUN.
//   Back-to-back: start=1 in the cycle where done=1 is accepted (busy=0 then).
//     Next result follows NSLICE cycles later.
//   Arithmetic: unsigned; sum = a + b + cin exactly; sum[WIDTH] is the carry-out/overflow bit.
//   Counter width: $clog2(NSLICE), minimum 1 bit; terminal compare on NSLICE-1, no wrap beyond.
//   sum changes only at completion edges or reset; never shows partial results.
// TESTING (WIDTH=8 unless stated)
//   a=3, b=5, cin=0, start one cycle -> busy 4 cycles; done pulses once; sum=9'd8.
//   a=8'hFF, b=8'h01, cin=0 -> sum=9'h100 (carry ripples through all 4 steps).
//   a=8'hFF, b=8'hFF, cin=1 -> sum=9'h1FF; then a=0, b=0, cin=0 -> sum=0.
//   Start 12+7 -> change a/b and pulse start on cycle 2 -> ignored; sum=19; single done.
//   Start 200+100 -> rst=1 on cycle 2 -> busy=0, done=0, sum=0 immediately.
//     After rst=0, next start still completes correctly.
//   Back-to-back: start held high -> done every 4 cycles; busy low 1 cycle between runs.
//   WIDTH=2: a=3, b=3, cin=1 -> busy 1 cycle; sum=3'd7.

Source files
------------

// File: rtl/serial_pair_adder_ctrl.sv
// serial_pair_adder_ctrl: adds two WIDTH-bit unsigned operands plus a carry-in.
// It uses one 2-bit adder slice and processes one bit pair per clock, least-significant pair first.
// The result is published with a single-cycle done pulse.
module serial_pair_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   sum_q;

  // Slice output for the current step, and the full result word it would complete.
  logic [2:0]       slice_d;
  logic [WIDTH-1:0] res_d;

  // One 2-bit slice: pair of A bits + pair of B bits + held carry, kept 3 bits wide.
  always_comb begin
    slice_d = 3'(a_sh_q[1:0]) + 3'(b_sh_q[1:0]) + 3'(carry_q);
  end

  // Partial result pairs live in a shift register that is fed from the MSB end.
  // The newest pair sits on top of it, so after the last step it holds the full sum bits in order.
  generate
    if (NSLICE > 1) begin : g_shift
      logic [WIDTH-3:0] res_sh_q;

      // Shift the freshly produced pair in at the top on every RUN step.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_sh_q <= '0;
        end else if (state_q == RUN) begin
          res_sh_q <= res_d[WIDTH-1:2];
        end
      end

      assign res_d = {slice_d[1:0], res_sh_q};
    end else begin : g_single
      assign res_d = slice_d[1:0];
    end
  endgenerate

  // Control FSM plus operand/carry/counter registers and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 2;
          b_sh_q  <= b_sh_q >> 2;
          carry_q <= slice_d[2];
          if (cnt_q == LAST) begin
            // Final step: the carry out of this slice becomes the result MSB.
            sum_q   <= {slice_d[2], res_d};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;

endmodule

// File: tb/tb_serial_pair_adder_ctrl.sv
// Bench for serial_pair_adder_ctrl.
// Stimulus pushes the expected sums into a queue, and a monitor pops and compares them on each done pulse.
// A second WIDTH=2 instance covers the single-slice case.
module tb_serial_pair_adder_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W:0]   sum;

  logic         start2 = 1'b0;
  logic         cin2 = 1'b0;
  logic [1:0]   a2 = '0;
  logic [1:0]   b2 = '0;
  logic         busy2;
  logic         done2;
  logic [2:0]   sum2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];
  int done_seen = 0;

  always #5 clk = ~clk;

  serial_pair_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum)
  );

  serial_pair_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cin(cin2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: score every done pulse, and also check the done pulse width and the busy run length.
  logic prev_done = 1'b0;
  int   busy_run  = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        done_seen++;
        check("done_width", 16'(prev_done), 16'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 16'd1, 16'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          $display("result: sum=0x%0h expected=0x%0h", sum, e);
          check("sum", 16'(sum), 16'(e));
        end
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", 16'(busy_run), 16'(NS));
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  // Issue one start pulse. On return we are at the negedge just after the accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = av; b = bv; cin = cv; start = 1'b1;
    if (push) exp_q.push_back((W+1)'(av) + (W+1)'(bv) + (W+1)'(cv));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 16'(busy), 16'd1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!done) check("done_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_sum",  16'(sum),  16'd0);
    check("rst_busy2", 16'(busy2), 16'd0);
    rst = 1'b0;

    start_op(8'd3,   8'd5,   1'b0, 1'b1); wait_done();
    start_op(8'hFF,  8'h01,  1'b0, 1'b1); wait_done();
    start_op(8'hFF,  8'hFF,  1'b1, 1'b1); wait_done();
    start_op(8'h00,  8'h00,  1'b0, 1'b1); wait_done();

    // A start pulse while busy is ignored, and sum keeps its old value until completion.
    start_op(8'd12, 8'd7, 1'b0, 1'b1);
    a = 8'd99; b = 8'd99; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sum_held", 16'(sum), 16'd0);
    wait_done();
    repeat (2) @(negedge clk);
    check("no_extra_done", 16'(done_seen), 16'd5);

    // Reset mid-run discards the operation immediately.
    start_op(8'd200, 8'd100, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_sum",  16'(sum),  16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_op(8'd3, 8'd5, 1'b0, 1'b1); wait_done();

    // Back-to-back runs with start held high.
    @(negedge clk);
    a = 8'd10; b = 8'd20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'd30);
    @(negedge clk);
    wait_done();
    check("b2b_gap_busy", 16'(busy), 16'd0);
    a = 8'd100; b = 8'd155; cin = 1'b1;
    exp_q.push_back(9'd256);
    @(negedge clk);
    check("b2b_rearm", 16'(busy), 16'd1);
    wait_done();
    start = 1'b0;
    repeat (NS + 2) @(negedge clk);
    check("b2b_stopped", 16'(busy), 16'd0);

    // WIDTH=2 instance: one slice step.
    a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("w2_busy", 16'(busy2), 16'd1);
    check("w2_done_early", 16'(done2), 16'd0);
    @(negedge clk);
    check("w2_done", 16'(done2), 16'd1);
    check("w2_sum",  16'(sum2),  16'd7);
    check("w2_idle", 16'(busy2), 16'd0);
    $display("result(W2): sum=%0d", sum2);

    repeat (3) @(negedge clk);
    check("sb_empty", 16'(exp_q.size()), 16'd0);
    check("done_total", 16'(done_seen), 16'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
